// File: rtl/local_bias_seq.sv
`default_nettype none
// ============================================================================
// Module   : local_bias_seq
// Purpose  : Power-up sequencer / supervisor for the local bias generator.
//            Debounces the analog supply in-range condition, raises the bias
//            block's pdb, verifies the returned bias currents after a settle
//            window with bounded retry, and then gates the analog testbus
//            select while reporting ready / fault status.
// Ports    :
//   clk                    sequencer clock
//   rstb                   synchronous active-low reset
//   i_en                   bias enable request from digital control
//   i_vddana_1p8           1.8 V supply sense (real)
//   i_vddana_0p8           0.8 V supply sense (real)
//   i_vssana               ground sense (real)
//   i_iclkdist_25ua        returned clock-distribution bias current (real)
//   i_icurrentsource_500ua returned current-source bias current (real)
//   i_atb_req[1:0]         requested testbus selection
//   o_pdb                  bias power-down-bar
//   o_atb_ena[1:0]         testbus enable (only non-zero while READY)
//   o_bias_ready           bias verified good
//   o_fault                sticky fault flag
//   o_fault_code[1:0]      00 none, 01 supply lost in READY,
//                          10 current check exhausted retries,
//                          11 current lost in READY
//   o_retry_cnt[1:0]       settle-check failures since last OFF
// Revision : 1.0 - initial release
// ============================================================================
module local_bias_seq #(
    parameter int  SUPPLY_DEB_CYC = 16,
    parameter int  SETTLE_CYC     = 64,
    parameter int  RETRY_MAX      = 3,
    parameter real SUP_TOL        = 0.05,
    parameter real CUR_TOL        = 0.10
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       i_en,
    input  real        i_vddana_1p8,
    input  real        i_vddana_0p8,
    input  real        i_vssana,
    input  real        i_iclkdist_25ua,
    input  real        i_icurrentsource_500ua,
    input  logic [1:0] i_atb_req,
    output logic       o_pdb,
    output logic [1:0] o_atb_ena,
    output logic       o_bias_ready,
    output logic       o_fault,
    output logic [1:0] o_fault_code,
    output logic [1:0] o_retry_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int  C_CNT_MAX = (SUPPLY_DEB_CYC > SETTLE_CYC) ? SUPPLY_DEB_CYC : SETTLE_CYC;
    localparam int  C_CNT_W   = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_DEB_END    = C_CNT_W'(SUPPLY_DEB_CYC);
    localparam logic [C_CNT_W-1:0] C_SETTLE_END = C_CNT_W'(SETTLE_CYC);
    localparam logic [1:0]         C_RETRY_MAX  = 2'(RETRY_MAX);

    localparam real C_V18_LO  = 1.8 * (1.0 - SUP_TOL);
    localparam real C_V18_HI  = 1.8 * (1.0 + SUP_TOL);
    localparam real C_V08_LO  = 0.8 * (1.0 - SUP_TOL);
    localparam real C_V08_HI  = 0.8 * (1.0 + SUP_TOL);
    // Ground window is absolute: the tolerance expressed in volts.
    localparam real C_VSS_LIM = SUP_TOL;

    localparam real C_I25_LO  = 25.0e-6  * (1.0 - CUR_TOL);
    localparam real C_I25_HI  = 25.0e-6  * (1.0 + CUR_TOL);
    localparam real C_I500_LO = 500.0e-6 * (1.0 - CUR_TOL);
    localparam real C_I500_HI = 500.0e-6 * (1.0 + CUR_TOL);

    localparam logic [1:0] C_CODE_NONE    = 2'b00;
    localparam logic [1:0] C_CODE_SUP     = 2'b01;
    localparam logic [1:0] C_CODE_RETRY   = 2'b10;
    localparam logic [1:0] C_CODE_CUR     = 2'b11;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_SUP_WAIT = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_READY    = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_retry;
    logic [1:0]           r_code;
    logic                 r_cur_bad;     // one failing current sample seen in READY
    logic                 r_pdb;
    logic [1:0]           r_atb_ena;
    logic                 r_bias_ready;
    logic                 r_fault;

    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]           w_retry_nxt;
    logic [1:0]           w_code_nxt;
    logic                 w_cur_bad_nxt;
    logic                 w_supply_ok;
    logic                 w_cur_ok;

    // ------------------------------------------------------------------------
    // Analog window comparators. Written as positive range tests so that a
    // NaN / undriven sense value fails every compare and reads as not-ok.
    // ------------------------------------------------------------------------
    always_comb begin
        w_supply_ok = (i_vddana_1p8 >= C_V18_LO)   && (i_vddana_1p8 <= C_V18_HI) &&
                      (i_vddana_0p8 >= C_V08_LO)   && (i_vddana_0p8 <= C_V08_HI) &&
                      (i_vssana     >= -C_VSS_LIM) && (i_vssana     <= C_VSS_LIM);
        w_cur_ok    = (i_iclkdist_25ua        >= C_I25_LO)  && (i_iclkdist_25ua        <= C_I25_HI) &&
                      (i_icurrentsource_500ua >= C_I500_LO) && (i_icurrentsource_500ua <= C_I500_HI);
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: en=0 > supply loss > settle expiry/current.
    // Counters compare against the registered count, so the transition edge
    // is the one after the count reaches its target; this gives pdb at
    // k+1+SUPPLY_DEB_CYC and bias_ready SETTLE_CYC+1 edges later.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retry_nxt   = r_retry;
        w_code_nxt    = r_code;
        w_cur_bad_nxt = 1'b0;

        if (!i_en) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
            w_retry_nxt = 2'd0;
            w_code_nxt  = C_CODE_NONE;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_SUP_WAIT;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = 2'd0;
                    w_code_nxt  = C_CODE_NONE;
                end

                ST_SUP_WAIT: begin
                    if (!w_supply_ok) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt >= C_DEB_END) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (!w_supply_ok) begin
                        // Supply dropout is not a bias failure: retry count kept.
                        w_state_nxt = ST_SUP_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= C_SETTLE_END) begin
                        w_cnt_nxt = '0;
                        if (w_cur_ok) begin
                            w_state_nxt = ST_READY;
                        end else if (r_retry < C_RETRY_MAX) begin
                            w_state_nxt = ST_SUP_WAIT;
                            w_retry_nxt = r_retry + 2'd1;
                        end else begin
                            w_state_nxt = ST_FAULT;
                            w_code_nxt  = C_CODE_RETRY;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                ST_READY: begin
                    if (!w_supply_ok) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = C_CODE_SUP;
                    end else if (!w_cur_ok) begin
                        // Two consecutive bad samples are needed; one is a glitch.
                        if (r_cur_bad) begin
                            w_state_nxt = ST_FAULT;
                            w_code_nxt  = C_CODE_CUR;
                        end else begin
                            w_cur_bad_nxt = 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    // Sticky until en drops.
                    w_state_nxt = ST_FAULT;
                end

                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = 2'd0;
                    w_code_nxt  = C_CODE_NONE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register. Outputs are decoded from the next state and registered
    // so that each output changes on the same edge as the state it reflects,
    // with no combinational input-to-output path.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_retry      <= 2'd0;
            r_code       <= C_CODE_NONE;
            r_cur_bad    <= 1'b0;
            r_pdb        <= 1'b0;
            r_atb_ena    <= 2'b00;
            r_bias_ready <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_code       <= w_code_nxt;
            r_cur_bad    <= w_cur_bad_nxt;
            r_pdb        <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_READY);
            r_bias_ready <= (w_state_nxt == ST_READY);
            r_atb_ena    <= (w_state_nxt == ST_READY) ? i_atb_req : 2'b00;
            r_fault      <= (w_state_nxt == ST_FAULT);
        end
    end

    assign o_pdb        = r_pdb;
    assign o_atb_ena    = r_atb_ena;
    assign o_bias_ready = r_bias_ready;
    assign o_fault      = r_fault;
    assign o_fault_code = r_code;
    assign o_retry_cnt  = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_local_bias_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_bias_seq
// Purpose  : Self-checking bench for local_bias_seq: power-up latency,
//            debounce restart, retry exhaustion, READY supervision, testbus
//            gating and mid-sequence reset. Expected values are hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_local_bias_seq;

    logic       clk = 1'b0;
    logic       rstb;
    logic       en;
    real        v18, v08, vss, i25, i500;
    logic [1:0] atb_req;
    logic       pdb;
    logic [1:0] atb_ena;
    logic       bias_ready;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;

    local_bias_seq dut (
        .clk                    (clk),
        .rstb                   (rstb),
        .i_en                   (en),
        .i_vddana_1p8           (v18),
        .i_vddana_0p8           (v08),
        .i_vssana               (vss),
        .i_iclkdist_25ua        (i25),
        .i_icurrentsource_500ua (i500),
        .i_atb_req              (atb_req),
        .o_pdb                  (pdb),
        .o_atb_ena              (atb_ena),
        .o_bias_ready           (bias_ready),
        .o_fault                (fault),
        .o_fault_code           (fault_code),
        .o_retry_cnt            (retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        real        v18, v08, vss, i25, i500;
        logic [1:0] atb;
        logic       rdy;
        logic [1:0] eatb;
        logic       flt;
        logic [1:0] code;
    } vec_t;

    vec_t rdy_tbl [13];
    vec_t sup_tbl [6];

    function automatic vec_t mk(input real a, input real b, input real c, input real d,
                                input real e, input logic [1:0] atb, input logic rdy,
                                input logic [1:0] eatb, input logic flt, input logic [1:0] code);
        vec_t v;
        v.v18 = a; v.v08 = b; v.vss = c; v.i25 = d; v.i500 = e;
        v.atb = atb; v.rdy = rdy; v.eatb = eatb; v.flt = flt; v.code = code;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic set_nominal();
        v18 = 1.8; v08 = 0.8; vss = 0.0; i25 = 25.0e-6; i500 = 500.0e-6;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pdb"},   pdb,        0);
        chk({tag, "_atb"},   atb_ena,    0);
        chk({tag, "_rdy"},   bias_ready, 0);
        chk({tag, "_flt"},   fault,      0);
        chk({tag, "_code"},  fault_code, 0);
        chk({tag, "_retry"}, retry_cnt,  0);
    endtask

    // Tick until pdb (which=0) or bias_ready (which=1) is high; -1 on timeout.
    task automatic wait_hi(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (((which == 0) ? pdb : bias_ready) === 1'b1) begin
                at = ecnt;
                break;
            end
        end
    endtask

    task automatic bring_up();
        int at;
        set_nominal();
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        wait_hi(1, 200, at);
        chk("bringup_ready_seen", (at != -1), 1);
    endtask

    initial begin
        int at, k, rises, falls;
        logic prev;

        // READY-state per-cycle vectors: inputs applied, outputs after the edge.
        rdy_tbl[0]  = mk(1.8,  0.8,  0.0,   25.0e-6, 500.0e-6, 2'b01, 1, 2'b01, 0, 2'b00);
        rdy_tbl[1]  = mk(1.8,  0.8,  0.0,   25.0e-6, 500.0e-6, 2'b10, 1, 2'b10, 0, 2'b00);
        rdy_tbl[2]  = mk(1.8,  0.8,  0.0,   25.0e-6, 500.0e-6, 2'b11, 1, 2'b11, 0, 2'b00);
        rdy_tbl[3]  = mk(1.72, 0.8,  0.0,   25.0e-6, 500.0e-6, 2'b00, 1, 2'b00, 0, 2'b00);
        rdy_tbl[4]  = mk(1.8,  0.83, -0.04, 25.0e-6, 500.0e-6, 2'b10, 1, 2'b10, 0, 2'b00);
        rdy_tbl[5]  = mk(1.8,  0.8,  0.0,   27.0e-6, 500.0e-6, 2'b01, 1, 2'b01, 0, 2'b00);
        rdy_tbl[6]  = mk(1.8,  0.8,  0.0,   25.0e-6, 460.0e-6, 2'b11, 1, 2'b11, 0, 2'b00);
        rdy_tbl[7]  = mk(1.8,  0.8,  0.0,   0.0,     500.0e-6, 2'b00, 1, 2'b00, 0, 2'b00);
        rdy_tbl[8]  = mk(1.8,  0.8,  0.0,   25.0e-6, 500.0e-6, 2'b01, 1, 2'b01, 0, 2'b00);
        rdy_tbl[9]  = mk(1.8,  0.8,  0.0,   25.0e-6, 560.0e-6, 2'b10, 1, 2'b10, 0, 2'b00);
        rdy_tbl[10] = mk(1.8,  0.8,  0.0,   25.0e-6, 500.0e-6, 2'b00, 1, 2'b00, 0, 2'b00);
        rdy_tbl[11] = mk(1.8,  0.8,  0.0,   22.0e-6, 500.0e-6, 2'b11, 1, 2'b11, 0, 2'b00);
        rdy_tbl[12] = mk(1.8,  0.8,  0.0,   22.0e-6, 500.0e-6, 2'b11, 0, 2'b00, 1, 2'b11);

        // Supply excursions in READY: each must fault with code 01.
        sup_tbl[0] = mk(1.60, 0.8,  0.0,   25.0e-6, 500.0e-6, 2'b11, 0, 2'b00, 1, 2'b01);
        sup_tbl[1] = mk(1.90, 0.8,  0.0,   25.0e-6, 500.0e-6, 2'b11, 0, 2'b00, 1, 2'b01);
        sup_tbl[2] = mk(1.8,  0.70, 0.0,   25.0e-6, 500.0e-6, 2'b11, 0, 2'b00, 1, 2'b01);
        sup_tbl[3] = mk(1.8,  0.85, 0.0,   25.0e-6, 500.0e-6, 2'b11, 0, 2'b00, 1, 2'b01);
        sup_tbl[4] = mk(1.8,  0.8,  0.06,  25.0e-6, 500.0e-6, 2'b11, 0, 2'b00, 1, 2'b01);
        sup_tbl[5] = mk(1.8,  0.8,  -0.06, 25.0e-6, 500.0e-6, 2'b11, 0, 2'b00, 1, 2'b01);

        // ---- 1: reset values and nominal power-up latency -------------------
        rstb = 1'b0; en = 1'b0; atb_req = 2'b00;
        set_nominal();
        tick(); tick(); tick();
        chk_reset_vals("reset");
        rstb = 1'b1;
        while (ecnt < 9) tick();
        en = 1'b1;                       // sampled at edge 10
        wait_hi(0, 100, at);
        chk("t1_pdb_edge", at, 27);
        chk("t1_retry", retry_cnt, 0);
        wait_hi(1, 100, at);
        chk("t1_ready_edge", at, 92);
        chk("t1_fault", fault, 0);
        chk("t1_pdb_ready", pdb, 1);

        // ---- 5 / atb: READY vector table ------------------------------------
        for (int i = 0; i < 13; i++) begin
            v18 = rdy_tbl[i].v18; v08 = rdy_tbl[i].v08; vss = rdy_tbl[i].vss;
            i25 = rdy_tbl[i].i25; i500 = rdy_tbl[i].i500; atb_req = rdy_tbl[i].atb;
            tick();
            chk($sformatf("rdy%0d_ready", i), bias_ready, rdy_tbl[i].rdy);
            chk($sformatf("rdy%0d_pdb",   i), pdb,        rdy_tbl[i].rdy);
            chk($sformatf("rdy%0d_atb",   i), atb_ena,    rdy_tbl[i].eatb);
            chk($sformatf("rdy%0d_fault", i), fault,      rdy_tbl[i].flt);
            chk($sformatf("rdy%0d_code",  i), fault_code, rdy_tbl[i].code);
        end
        atb_req = 2'b00;
        en = 1'b0;
        tick();
        chk("clr_fault", fault, 0);
        chk("clr_code", fault_code, 0);

        // ---- 2: supply glitch during debounce --------------------------------
        set_nominal();
        en = 1'b1;
        tick();
        k = ecnt;                        // en sampled here; counter = 10 at k+10
        repeat (10) tick();
        v08 = 0.70;
        repeat (3) tick();
        chk("t2_pdb_low_glitch", pdb, 0);
        v08 = 0.8;
        wait_hi(0, 100, at);
        chk("t2_pdb_edge", at, k + 30);

        // ---- 3: current check exhausts retries -------------------------------
        en = 1'b0;
        tick();
        i25 = 0.0; i500 = 0.0;
        en = 1'b1;
        tick();
        k = ecnt;
        rises = 0; falls = 0; prev = pdb;
        for (int i = 0; i < 330; i++) begin
            tick();
            if (pdb && !prev) rises++;
            if (!pdb && prev) falls++;
            prev = pdb;
            if (ecnt == k + 81)  chk("t3_pdb_before_fail", pdb, 1);
            if (ecnt == k + 82)  chk("t3_retry1", retry_cnt, 1);
            if (ecnt == k + 164) chk("t3_retry2", retry_cnt, 2);
            if (ecnt == k + 246) chk("t3_retry3", retry_cnt, 3);
            if (ecnt == k + 328) begin
                chk("t3_fault", fault, 1);
                chk("t3_code", fault_code, 2'b10);
                chk("t3_pdb", pdb, 0);
            end
        end
        chk("t3_pdb_rises", rises, 4);
        chk("t3_pdb_falls", falls, 4);
        chk("t3_fault_sticky", fault, 1);
        en = 1'b0;
        tick();
        chk("t3_clr_fault", fault, 0);
        chk("t3_clr_code", fault_code, 0);
        chk("t3_clr_retry", retry_cnt, 0);
        set_nominal();
        en = 1'b1;
        tick();
        k = ecnt;
        wait_hi(0, 100, at);
        chk("t3_restart_pdb", at, k + 17);

        // ---- 6: reset pulse during SETTLE ------------------------------------
        repeat (5) tick();
        rstb = 1'b0;
        tick();
        chk_reset_vals("t6");
        rstb = 1'b1;
        k = ecnt;
        wait_hi(0, 100, at);
        chk("t6_restart_pdb", at, k + 18);

        // ---- 4: supply loss in READY (table) ---------------------------------
        for (int i = 0; i < 6; i++) begin
            bring_up();
            atb_req = 2'b11;
            tick();
            chk($sformatf("sup%0d_atb_follow", i), atb_ena, 2'b11);
            v18 = sup_tbl[i].v18; v08 = sup_tbl[i].v08; vss = sup_tbl[i].vss;
            tick();
            chk($sformatf("sup%0d_fault", i), fault,      sup_tbl[i].flt);
            chk($sformatf("sup%0d_code",  i), fault_code, sup_tbl[i].code);
            chk($sformatf("sup%0d_atb",   i), atb_ena,    sup_tbl[i].eatb);
            chk($sformatf("sup%0d_pdb",   i), pdb,        sup_tbl[i].rdy);
            atb_req = 2'b00;
        end

        // ---- en=0 while READY -------------------------------------------------
        bring_up();
        atb_req = 2'b11;
        tick();
        en = 1'b0;
        tick();
        chk("off_pdb", pdb, 0);
        chk("off_ready", bias_ready, 0);
        chk("off_atb", atb_ena, 0);
        tick();
        chk("off_atb_gated", atb_ena, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/local_bias_seq.md
Name: local_bias_seq

Overview:
Power-up sequencer and supervisor placed directly upstream of the local bias generator. It samples the analog supplies (real), debounces their in-range condition, and drives the bias block's pdb. It then checks the returned bias currents after a settle window, with bounded retry. Once the bias is proven good it gates the analog testbus select and reports ready/fault status to digital control.

Parameters:
SUPPLY_DEB_CYC, 16, consecutive in-range clk cycles required before enabling bias (>=1)
SETTLE_CYC, 64, clk cycles pdb is held high before bias currents are checked (>=1)
RETRY_MAX, 3, settle-check failures tolerated before FAULT (0..3)
SUP_TOL, 0.05, relative supply tolerance (±5% of 1.8 V / 0.8 V; vssana within ±0.05 V)
CUR_TOL, 0.10, relative current tolerance around 25 µA / 500 µA

Ports:
clk  input  1  sequencer clock
rstb  input  1  synchronous active-low reset
en  input  1  bias enable request from digital control
vddana_1p8  input  real  1.8 V supply sense
vddana_0p8  input  real  0.8 V supply sense
vssana  input  real  ground sense
iclkdist_25ua  input  real  returned clock-distribution bias current
icurrentsource_500ua  input  real  returned current-source bias current
atb_req  input  2  requested testbus selection
pdb  output  1  bias power-down-bar to bias block
atb_ena  output  2  testbus enable to bias block
bias_ready  output  1  bias verified good
fault  output  1  sticky fault flag
fault_code  output  2  00 none, 01 supply lost in READY, 10 current check exhausted retries, 11 current lost in READY
retry_cnt  output  2  settle-check failures since last OFF

Behaviour:
- Clock/reset: one clock; reset synchronous, active-low. rstb low at a clk edge -> state OFF; pdb=0, atb_ena=00, bias_ready=0, fault=0, fault_code=00, retry_cnt=0, counters cleared. Applies identically mid-operation.
- All outputs registered. No combinational path from any input to any output.
- supply_ok (combinational, sampled at posedge): 1.71<=vddana_1p8<=1.89, 0.76<=vddana_0p8<=0.84, -0.05<=vssana<=0.05. Any Z/X real fails the compare and reads as not-ok.
- cur_ok (combinational, sampled at posedge): both currents within ±CUR_TOL of nominal. Z-state (pdb low) reads as not-ok.
- States: OFF, SUP_WAIT, SETTLE, READY, FAULT.
- OFF: pdb=0, bias_ready=0. en=1 -> SUP_WAIT; debounce counter cleared.
- SUP_WAIT: pdb=0. Counter increments each supply_ok cycle and clears to 0 on any not-ok cycle. Reaching SUPPLY_DEB_CYC -> SETTLE; pdb=1 from that edge.
- SETTLE: pdb=1. Counter counts SETTLE_CYC cycles.
  - supply_ok drop -> SUP_WAIT, pdb=0, retry_cnt unchanged.
  - At expiry with cur_ok=1 -> READY.
  - At expiry with cur_ok=0 and retry_cnt<RETRY_MAX -> retry_cnt+1, SUP_WAIT, pdb=0.
  - At expiry with cur_ok=0 and retry_cnt=RETRY_MAX -> FAULT, fault_code=10.
- READY: pdb=1, bias_ready=1, atb_ena follows atb_req with one cycle latency.
  - supply not-ok -> FAULT, code 01.
  - cur_ok=0 for 2 consecutive cycles -> FAULT, code 11. A single-cycle glitch is ignored.
- FAULT: pdb=0, bias_ready=0, atb_ena=00, fault=1. fault_code is held. Exit only via en=0 -> OFF, which clears fault, fault_code and retry_cnt.
- en=0 in any state -> OFF at next edge, pdb=0, atb_ena=00.
- Outside READY, atb_ena=00 regardless of atb_req.
- Priority: rstb > en=0 > supply loss > settle expiry/current check.
- Latency: supplies valid and en sampled high at edge k -> pdb=1 at edge k+1+SUPPLY_DEB_CYC; bias_ready=1 at SETTLE_CYC+1 edges after that.
- retry_cnt saturates at RETRY_MAX.

Test Plan:
1. Defaults, supplies 1.8/0.8/0.0, currents nominal, en high at edge 10 -> pdb high at edge 27, bias_ready high at edge 92, fault=0, retry_cnt=0.
2. vddana_0p8=0.70 V for 3 cycles at debounce count 10 -> counter clears; pdb rises 16 in-range cycles after recovery.
3. Currents held at 0 after pdb -> pdb pulses low/high through retries, retry_cnt reaches 3, 4th failure -> fault=1, fault_code=10, pdb=0; en low then high -> fault clears, sequence restarts.
4. In READY, atb_req=11 -> atb_ena=11 next cycle. Then vddana_1p8=1.60 V -> next edge FAULT, fault_code=01, atb_ena=00, pdb=0.
5. In READY, iclkdist_25ua=0 for 1 cycle -> stays READY; for 2 cycles -> fault_code=11.
6. rstb low for one edge during SETTLE -> next edge all outputs at reset values; with en still high, sequence restarts from SUP_WAIT with full debounce.
